sobel_x: RTL and testbench
==========================

Name: sobel_x

Overview:
- Streaming horizontal-gradient (Sobel X) filter for 8-bit grayscale samples arriving one per clock in raster order.
- Uses two line buffers and a 3x3 window. Outputs the saturated absolute X-gradient of each window as one 8-bit result.
- Sits between an image sample source and a result sink. The data path is 32 bits wide for bus compatibility, but only byte 0 carries data.

Parameters:
- IMG_WIDTH, 512, samples per image line (line-buffer depth); minimum 3.
- DATA_W, 8, significant pixel bits taken from stream_input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample-accept enable; stream_input is consumed on each rising edge where en=1.
- stream_input  input  32  pixel sample in bits [7:0]; bits [31:8] ignored.
- stream_output  output  32  |Gx| saturated to 8 bits in [7:0]; bits [31:8] always 0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n=0 clears both line buffers, all 9 window registers, the en_d flag and stream_output to 0, immediately and regardless of clk.
- Accept (rising edge, en=1), with p = stream_input[7:0]:
  - Line buffer 1 (IMG_WIDTH-deep shift register) shifts in p; its output is lb1.
  - Line buffer 2 (IMG_WIDTH-deep) shifts in lb1; its output is lb2.
  - Window columns shift left (col0 <- col1 <- col2).
  - The new col2 is {top=lb2, mid=lb1, bot=p}, using the values present before the edge.
- en=0: line buffers and window hold unchanged.
- Gradient:
  - S(col) = top + 2*mid + bot (10-bit unsigned).
  - Gx = S(col2) - S(col0), computed as 11-bit signed, range -1020..+1020.
  - mag = |Gx|; result = 255 if mag > 255, else mag[7:0].
- Output register:
  - en_d is en registered each cycle.
  - On a rising edge with en_d=1, stream_output <= {24'b0, result} computed from the current window.
  - Otherwise stream_output holds.
- Latency: the sample presented at edge k affects stream_output after edge k+1, i.e. one cycle after the window update.
- After en falls, stream_output updates exactly once more (for the final window), then holds.
- Borders:
  - No masking and no padding.
  - Zeros from reset fill the buffers during the first 2*IMG_WIDTH+2 accepted samples.
  - Windows straddling a line boundary are computed as-is, wrapping onto the previous line.
  - The downstream consumer discards border results.
- Continuous streaming: one accepted sample per clock, no stalls, no backpressure.
- Reset mid-stream: all state is lost and the filter restarts with empty (zero) buffers on the next accepted sample.
- Bits [31:8] of stream_input never influence any state.

Test Plan:
All scenarios use IMG_WIDTH=8 unless noted.
1. Reset: assert rst_n=0 mid-clock with the window holding nonzero data -> stream_output=0 immediately. After release with en=0 -> stays 0.
2. Flat image: stream a constant 100 with en=1 -> once 2*8+3 samples are accepted, every subsequent stream_output = 0.
3. Vertical step: each line is 0,0,0,0,50,50,50,50, for 4 lines.
   - Rows 3-4, window columns 3-5 -> Gx = 4*50 = 200; output 200.
   - Windows wholly inside a flat region output 0.
4. Negative step and saturation:
   - Lines of 50,50,50,50,0,0,0,0 -> the same positions output 200 (absolute value).
   - Lines of 0,...,0,255,255,255,255 -> output 255 (1020 saturated).
5. Enable gating:
   - Drop en for 5 cycles mid-stream -> stream_output changes once on the first low cycle, then holds.
   - On resume, the result sequence equals that of an uninterrupted stream.
6. Upper-bit independence: drive stream_input[31:8]=0xFFFFFF with a random low byte -> outputs identical to the same stream with the upper bits 0; stream_output[31:8] always 0.

Source files
------------

// File: rtl/sobel_x.sv
// sobel_x: streaming horizontal-gradient (Sobel X) filter.
// Grayscale samples arrive one per clock in raster order. Two line buffers and a
// 3x3 window produce, one cycle after each window update, the saturated
// absolute X gradient of the window.
//
// Ports:
//   clk           - system clock, rising edge
//   rst_n         - asynchronous active-low reset
//   en            - sample-accept enable
//   stream_input  - pixel sample in [DATA_W-1:0], upper bits ignored
//   stream_output - |Gx| saturated to 8 bits in [7:0], upper bits always 0
module sobel_x #(
    parameter int unsigned IMG_WIDTH = 512,
    parameter int unsigned DATA_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] stream_input,
    output logic [31:0] stream_output
);

    typedef logic [DATA_W-1:0] pix_t;

    pix_t        lb1_q [IMG_WIDTH];
    pix_t        lb1_d [IMG_WIDTH];
    pix_t        lb2_q [IMG_WIDTH];
    pix_t        lb2_d [IMG_WIDTH];
    // win[col][row]: col 0 is oldest, row 0 is top
    pix_t        win_q [3][3];
    pix_t        win_d [3][3];
    logic        en_d_q;
    logic        en_d_d;
    logic [7:0]  res_q;
    logic [7:0]  res_d;

    pix_t        pix;
    pix_t        lb1_out;
    pix_t        lb2_out;
    logic [DATA_W+1:0] s_col0;
    logic [DATA_W+1:0] s_col2;
    logic [DATA_W+2:0] gx;
    logic [DATA_W+2:0] mag;
    logic [7:0]        result;
    logic              unused_hi;

    assign pix       = stream_input[DATA_W-1:0];
    assign unused_hi = ^stream_input[31:DATA_W];
    assign lb1_out   = lb1_q[IMG_WIDTH-1];
    assign lb2_out   = lb2_q[IMG_WIDTH-1];

    // Column sums and gradient; the subtraction wraps in DATA_W+3 bits so the
    // MSB acts as the sign of Gx.
    always_comb begin
        s_col0 = {2'b00, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b00, win_q[0][2]};
        s_col2 = {2'b00, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b00, win_q[2][2]};
        gx     = {1'b0, s_col2} - {1'b0, s_col0};
        mag    = gx[DATA_W+2] ? ('0 - gx) : gx;
        result = (mag > (DATA_W+3)'(255)) ? 8'hFF : mag[7:0];
    end

    always_comb begin
        lb1_d  = lb1_q;
        lb2_d  = lb2_q;
        win_d  = win_q;
        en_d_d = en;
        res_d  = res_q;
        if (en) begin
            lb1_d[0] = pix;
            lb2_d[0] = lb1_out;
            for (int unsigned i = 1; i < IMG_WIDTH; i++) begin
                lb1_d[i] = lb1_q[i-1];
                lb2_d[i] = lb2_q[i-1];
            end
            win_d[0]    = win_q[1];
            win_d[1]    = win_q[2];
            win_d[2][0] = lb2_out;
            win_d[2][1] = lb1_out;
            win_d[2][2] = pix;
        end
        if (en_d_q) begin
            res_d = result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb1_q  <= '{default: '0};
            lb2_q  <= '{default: '0};
            win_q  <= '{default: '{default: '0}};
            en_d_q <= 1'b0;
            res_q  <= '0;
        end else begin
            lb1_q  <= lb1_d;
            lb2_q  <= lb2_d;
            win_q  <= win_d;
            en_d_q <= en_d_d;
            res_q  <= res_d;
        end
    end

    assign stream_output = {24'b0, res_q};

endmodule

// File: tb/tb_sobel_x.sv
// tb_sobel_x: self-checking bench for sobel_x with IMG_WIDTH=8.
// The reference keeps the full history of accepted samples and derives each
// window pixel by indexing back into that history (zero before the start).
module tb_sobel_x;

    localparam int W = 8;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] stream_input;
    logic [31:0] stream_output;

    int          vectors;
    int          miscompares;
    int          hist[$];
    logic [31:0] exp_out;
    bit          prev_en;
    int          max_seen;
    int          lowb[24];

    sobel_x #(.IMG_WIDTH(W), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .stream_input (stream_input),
        .stream_output(stream_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pixel accepted 'back' samples before the most recent one.
    function automatic int px(input int back);
        int idx;
        idx = hist.size() - 1 - back;
        return (idx < 0) ? 0 : hist[idx];
    endfunction

    // Column sum for the column 'age' samples old (0 = newest column).
    function automatic int col_sum(input int age);
        return px(age + 2*W) + 2*px(age + W) + px(age);
    endfunction

    function automatic int model_result();
        int g;
        g = col_sum(0) - col_sum(2);
        if (g < 0) g = -g;
        return (g > 255) ? 255 : g;
    endfunction

    task automatic check(input string tag, input logic [31:0] e);
        vectors++;
        assert (stream_output === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, stream_output, e);
        end
    endtask

    task automatic drive(input bit e, input logic [31:0] d, input string tag);
        en = e;
        stream_input = d;
        @(posedge clk);
        if (prev_en) exp_out = 32'(model_result());
        prev_en = e;
        if (e) hist.push_back(int'(d[7:0]));
        #1;
        check(tag, exp_out);
        if (int'(stream_output[7:0]) > max_seen) max_seen = int'(stream_output[7:0]);
    endtask

    // Asynchronous reset asserted mid-cycle; output must clear at once.
    task automatic do_reset(input string tag);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        hist.delete();
        exp_out = '0;
        prev_en = 1'b0;
        check(tag, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic line_image(input int a, input int b, input string tag);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, {$urandom_range(0, 1) == 0 ? 24'h0 : 24'($urandom), (c < 4) ? 8'(a) : 8'(b)}, tag);
            end
        end
        drive(1'b0, 32'h0, tag);
        drive(1'b0, 32'h0, tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_out     = '0;
        prev_en     = 1'b0;
        max_seen    = 0;
        rst_n        = 1'b0;
        en           = 1'b0;
        stream_input = '0;
        #12;
        check("reset_init", 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, "idle_after_reset");

        // Flat image: output settles to 0
        for (int i = 0; i < 30; i++) drive(1'b1, {24'($urandom), 8'd100}, "flat");

        // Vertical rising step
        do_reset("reset_before_step");
        max_seen = 0;
        line_image(0, 50, "step_up");
        vectors++;
        assert (max_seen === 200) else begin
            miscompares++;
            $error("FAIL step_up_peak: observed %0d expected %0d", max_seen, 200);
        end

        // Falling step: absolute value
        do_reset("reset_before_fall");
        max_seen = 0;
        line_image(50, 0, "step_down");
        vectors++;
        assert (max_seen === 200) else begin
            miscompares++;
            $error("FAIL step_down_peak: observed %0d expected %0d", max_seen, 200);
        end

        // Saturation: 1020 clips to 255
        do_reset("reset_before_sat");
        max_seen = 0;
        line_image(0, 255, "saturate");
        vectors++;
        assert (max_seen === 255) else begin
            miscompares++;
            $error("FAIL saturate_peak: observed %0d expected %0d", max_seen, 255);
        end

        // Enable gating with random data
        do_reset("reset_before_gate");
        for (int i = 0; i < 26; i++) drive(1'b1, $urandom, "gate_pre");
        for (int i = 0; i < 5; i++)  drive(1'b0, $urandom, "gate_low");
        for (int i = 0; i < 26; i++) drive(1'b1, $urandom, "gate_post");
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)), $urandom, "gate_random");

        // Upper-bit independence: same low bytes with upper bits all ones, then zero
        for (int i = 0; i < 24; i++) lowb[i] = int'($urandom_range(0, 255));
        do_reset("reset_before_upper1");
        for (int i = 0; i < 24; i++) drive(1'b1, {24'hFFFFFF, 8'(lowb[i])}, "upper_ones");
        drive(1'b0, 32'h0, "upper_ones");
        do_reset("reset_before_upper0");
        for (int i = 0; i < 24; i++) drive(1'b1, {24'h000000, 8'(lowb[i])}, "upper_zero");
        drive(1'b0, 32'h0, "upper_zero");

        // Reset mid-stream with a populated window, then stay idle
        for (int i = 0; i < 20; i++) drive(1'b1, {24'h0, 8'($urandom_range(128, 255))}, "pre_reset");
        do_reset("reset_midstream");
        for (int i = 0; i < 3; i++) drive(1'b0, $urandom, "idle_after_midreset");
        for (int i = 0; i < 20; i++) drive(1'b1, $urandom, "restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
